ysyx_22040931_bus_arbiter: RTL
==============================

# ysyx_22040931_bus_arbiter

Two-master, one-slave memory arbiter between the fetch stage and the MEM stage, sharing the single core memory port. It accepts one request at a time, registers it, issues it on the bus, and routes the response back to the owner. Fetch responses are discarded if a pipeline flush arrives while the fetch is outstanding. It sits between IF/MEM and the bus bridge, and drives the fetch stage's `if_ready`.

## Interface
- `ADDR_W`, 64, address width (PC bus width)
- `DATA_W`, 64, data width; `DATA_W/8` = mask width
- `clock` in 1: single clock
- `reset` in 1: synchronous, active-high
- `flush` in 1: pipeline redirect (mispredict or exception)
- `if_req_valid` in 1: fetch request (read only)
- `if_req_ready` out 1: fetch request accepted this cycle; feeds IF `if_ready`
- `if_addr` in ADDR_W: fetch PC
- `if_resp_valid` out 1: fetch data valid (1-cycle pulse)
- `if_rdata` out DATA_W: fetch data
- `mem_req_valid` in 1: load/store request
- `mem_req_ready` out 1: load/store accepted this cycle
- `mem_wen` in 1: 1 = store
- `mem_addr` in ADDR_W: load/store address
- `mem_wdata` in DATA_W: store data
- `mem_wmask` in DATA_W/8: store byte mask
- `mem_resp_valid` out 1: load data valid or store done (pulse)
- `mem_rdata` out DATA_W: load data
- `bus_req_valid` out 1: request to the bus
- `bus_req_ready` in 1: bus accepts the request
- `bus_wen` out 1: write
- `bus_addr` out ADDR_W: registered address
- `bus_wdata` out DATA_W: registered data
- `bus_wmask` out DATA_W/8: registered mask; all-zero for reads
- `bus_resp_valid` in 1: bus response (1 cycle)
- `bus_rdata` in DATA_W: bus read data

## Operation
- States: IDLE, ISSUE, WAIT. Registers: `owner` (0 = IF, 1 = MEM), `drop`, request latch (addr, wdata, wmask, wen).
- IDLE:
  - `mem_req_ready = mem_req_valid`.
  - `if_req_ready = if_req_valid & ~mem_req_valid & ~flush`.
  - MEM has fixed priority, since an older instruction blocks the pipeline and IF cannot starve it.
  - On acceptance, latch the request, set `owner`, clear `drop`, and go to ISSUE.
  - IF requests force `wen = 0` and `wmask = 0`.
- ISSUE: `bus_req_valid = 1`. On `bus_req_ready`, go to WAIT.
- WAIT:
  - On `bus_resp_valid`, go to IDLE.
  - If `owner = MEM`: `mem_resp_valid = 1` and `mem_rdata = bus_rdata`, same cycle (combinational).
  - If `owner = IF` and `~drop` and `~flush`: `if_resp_valid = 1` and `if_rdata = bus_rdata`.
  - Otherwise the response is consumed silently.
- Flush:
  - With `owner = IF` in ISSUE or WAIT, set `drop`. The bus transaction still completes and is never aborted.
  - A flush in the same cycle as the response also suppresses `if_resp_valid`.
  - MEM transactions ignore `flush`.
- Ready outputs are 0 in ISSUE and WAIT: exactly one transaction is outstanding.
- Outside a valid pulse, `if_rdata` and `mem_rdata` are don't-care; the implementation drives them with `bus_rdata`.

## Timing
- Reset: state IDLE, `owner = 0`, `drop = 0`, latch cleared. All outputs 0 except `if_req_ready` and `mem_req_ready`, which follow their combinational IDLE equations above.
- Reset mid-transaction: state returns to IDLE. Any later `bus_resp_valid` while in IDLE is ignored.
- Request accepted in cycle N; `bus_req_valid` is high from N+1 until the handshake.
- With `bus_req_ready` held at 1 and the response one cycle after acceptance, the response arrives in N+2. Minimum requester-to-response latency is therefore 2 cycles.
- The response cycle returns to IDLE. The next request can be accepted at the earliest in the cycle after the response, so back-to-back throughput is 1 transaction per 3 cycles at minimum bus latency.
- `bus_addr`, `bus_wdata`, `bus_wmask` and `bus_wen` come from registers and are stable for the whole of ISSUE.
- Simultaneous IF and MEM valid in IDLE: MEM is granted and IF sees `if_req_ready = 0`. IF must hold `if_req_valid` and `if_addr` until it is accepted, or until it withdraws them on flush.

## Test plan
- Single fetch: `if_req_valid = 1`, `if_addr = 0x80000000`, bus ready immediately, `bus_rdata = 0x00000013` at N+2. Required: `if_req_ready` in N, `bus_addr = 0x80000000` with `bus_wen = 0` in N+1, `if_resp_valid` with that data in N+2, no `mem_resp_valid`.
- Conflict: IF and MEM (store to `0x80001000`, `wdata 0xDEADBEEF`, `wmask 0x0F`) both valid in IDLE. Required: the store is issued first with mask `0x0F`. The fetch is accepted in the cycle after the store response and completes 2 cycles later.
- Flush in WAIT: fetch outstanding, `flush` pulsed for 1 cycle, bus response 3 cycles later. Required: `if_resp_valid` stays 0, state returns to IDLE, and the next fetch completes normally.
- Flush in IDLE: `flush = 1` together with `if_req_valid`. Required: `if_req_ready = 0` and no bus request. Then a MEM load during flush is accepted normally, and `mem_resp_valid` is delivered even if `flush` is high at the response.
- Bus backpressure: `bus_req_ready` held 0 for 5 cycles during ISSUE. Required: `bus_req_valid` and address stay constant, and both requesters see ready = 0 throughout.
- Reset in WAIT: state goes to IDLE and all outputs return to reset values. A stray `bus_resp_valid` afterwards produces no `if_resp_valid` or `mem_resp_valid`.

Source files
------------

// File: rtl/ysyx_22040931_bus_arbiter.sv
// rtl/ysyx_22040931_bus_arbiter.sv - two-master (fetch, MEM) to one-slave memory port arbiter
module ysyx_22040931_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req_valid,
    output logic                mem_req_ready,
    input  logic                mem_wen,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_resp_valid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_wen,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wmask,
    input  logic                bus_resp_valid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic                owner;
    logic                drop;
    logic                req_wen;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wmask;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MEM wins in IDLE: an older instruction is stalled behind it, so fetch must yield.
    always_comb begin
        state_next     = state;
        if_req_ready   = 1'b0;
        mem_req_ready  = 1'b0;
        bus_req_valid  = 1'b0;
        if_resp_valid  = 1'b0;
        mem_resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                mem_req_ready = mem_req_valid;
                if_req_ready  = if_req_valid & ~mem_req_valid & ~flush;
                if (mem_req_valid | if_req_ready) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_resp_valid) begin
                    state_next     = S_IDLE;
                    mem_resp_valid = owner;
                    if_resp_valid  = ~owner & ~drop & ~flush;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner     <= 1'b0;
            drop      <= 1'b0;
            req_wen   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
        end else if (state == S_IDLE) begin
            if (mem_req_valid) begin
                owner     <= 1'b1;
                drop      <= 1'b0;
                req_wen   <= mem_wen;
                req_addr  <= mem_addr;
                req_wdata <= mem_wdata;
                req_wmask <= mem_wen ? mem_wmask : '0;
            end else if (if_req_ready) begin
                owner     <= 1'b0;
                drop      <= 1'b0;
                req_wen   <= 1'b0;
                req_addr  <= if_addr;
                req_wmask <= '0;
            end
        end else if (~owner & flush) begin
            // The bus beat still completes; only its delivery to fetch is cancelled.
            drop <= 1'b1;
        end
    end

    assign bus_wen   = req_wen;
    assign bus_addr  = req_addr;
    assign bus_wdata = req_wdata;
    assign bus_wmask = req_wmask;
    assign if_rdata  = bus_rdata;
    assign mem_rdata = bus_rdata;

endmodule
